fsm_cfg_sched: RTL and testbench

//  Configures and sequences the 9-state programmable FSM (codes c0..c8, enable, reset).

---
 rtl/fsm_cfg_pkg.sv | 19 +
 rtl/fsm_cfg_table.sv | 101 ++++++++++
 rtl/fsm_cfg_sched.sv | 132 +++++++++++++
 tb/tb_fsm_cfg_sched.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_cfg_pkg.sv
// Shared constants for the programmable-FSM configuration sequencer.
// Holds table geometry, counter width and the sequencer state encoding.
package fsm_cfg_pkg;

   localparam int N_STATES = 9;
   localparam int W        = 4;
   localparam int STEP_W   = 8;
   localparam int IDX_W    = 4;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CHECK = 3'd1;
   localparam logic [2:0] S_READY = 3'd2;
   localparam logic [2:0] S_INIT  = 3'd3;
   localparam logic [2:0] S_RUN   = 3'd4;
   localparam logic [2:0] S_DRAIN = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;
   localparam logic [2:0] S_ERR   = 3'd7;

endpackage

// File: rtl/fsm_cfg_table.sv
// State-code table with loaded mask and write port, plus a one-pair-per-cycle
// duplicate sweep over all (i<j) pairs in i-major order.
module fsm_cfg_table #(
   parameter int N_STATES = fsm_cfg_pkg::N_STATES,
   parameter int W        = fsm_cfg_pkg::W
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          wr_en,
   input  logic                          clr,
   input  logic [fsm_cfg_pkg::IDX_W-1:0] wr_idx,
   input  logic [W-1:0]                  wr_code,
   input  logic                          sweep_start,
   input  logic                          sweep_en,
   output logic [N_STATES*W-1:0]         codes,
   output logic                          all_loaded,
   output logic                          bad_idx,
   output logic                          sweep_done,
   output logic                          dup_found
);

   localparam int IW = fsm_cfg_pkg::IDX_W;
   localparam logic [IW-1:0] LAST_IDX = IW'(N_STATES - 1);
   localparam logic [IW-1:0] LAST_I   = IW'(N_STATES - 2);

   logic [N_STATES-1:0] loaded;
   logic                bad_reg;
   logic                dup_reg;
   logic [IW-1:0]       i_reg;
   logic [IW-1:0]       j_reg;
   logic [W-1:0]        code_i;
   logic [W-1:0]        code_j;
   logic                match;
   logic                in_range;

   assign in_range = (wr_idx <= LAST_IDX);

   genvar gi;
   generate
      for (gi = 0; gi < N_STATES; gi++) begin : g_entry
         logic [W-1:0] code_reg;
         logic         loaded_reg;
         logic         hit;

         assign hit = wr_en && (wr_idx == IW'(gi));

         always_ff @(posedge clock) begin
            if (reset) begin
               code_reg   <= '0;
               loaded_reg <= 1'b0;
            end else if (hit) begin
               code_reg   <= wr_code;
               loaded_reg <= 1'b1;
            end else if (clr) begin
               loaded_reg <= 1'b0;
            end
         end

         assign codes[gi*W +: W] = code_reg;
         assign loaded[gi]       = loaded_reg;
      end
   endgenerate

   // A write that both clears and is out of range leaves the flag set.
   always_ff @(posedge clock) begin
      if (reset) begin
         bad_reg <= 1'b0;
      end else if (wr_en && !in_range) begin
         bad_reg <= 1'b1;
      end else if (clr) begin
         bad_reg <= 1'b0;
      end
   end

   assign all_loaded = &loaded;
   assign bad_idx    = bad_reg;

   assign code_i     = codes[i_reg*W +: W];
   assign code_j     = codes[j_reg*W +: W];
   assign match      = (code_i == code_j);
   assign sweep_done = sweep_en && (i_reg == LAST_I) && (j_reg == LAST_IDX);
   assign dup_found  = dup_reg | match;

   // Counters park on the final pair so the muxes never index past the table.
   always_ff @(posedge clock) begin
      if (reset || sweep_start) begin
         i_reg   <= '0;
         j_reg   <= IW'(1);
         dup_reg <= 1'b0;
      end else if (sweep_en && !sweep_done) begin
         dup_reg <= dup_reg | match;
         if (j_reg == LAST_IDX) begin
            i_reg <= i_reg + IW'(1);
            j_reg <= i_reg + IW'(2);
         end else begin
            j_reg <= j_reg + IW'(1);
         end
      end
   end

endmodule

// File: rtl/fsm_cfg_sched.sv
// Sequencer for the programmable FSM: loads and validates its state-code table,
// then runs it for a programmed number of enabled steps and counts laps through c0.
module fsm_cfg_sched #(
   parameter int N_STATES = fsm_cfg_pkg::N_STATES,
   parameter int W        = fsm_cfg_pkg::W,
   parameter int STEP_W   = fsm_cfg_pkg::STEP_W
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          cfg_valid,
   output logic                          cfg_ready,
   input  logic [fsm_cfg_pkg::IDX_W-1:0] cfg_idx,
   input  logic [W-1:0]                  cfg_code,
   input  logic                          cfg_last,
   input  logic                          start,
   input  logic [STEP_W-1:0]             steps,
   input  logic [W-1:0]                  fsm_y,
   output logic [N_STATES*W-1:0]         fsm_codes,
   output logic                          fsm_reset,
   output logic                          fsm_en,
   output logic                          busy,
   output logic                          done,
   output logic                          err,
   output logic [STEP_W-1:0]             laps
);

   import fsm_cfg_pkg::*;

   logic [2:0]        state_reg;
   logic [2:0]        state_next;
   logic [STEP_W-1:0] budget_reg;
   logic [STEP_W-1:0] step_cnt_reg;
   logic [STEP_W-1:0] laps_reg;
   logic              en_d_reg;

   logic wr_acc;
   logic clr;
   logic sweep_start;
   logic sweep_en;
   logic all_loaded;
   logic bad_idx;
   logic sweep_done;
   logic dup_found;

   assign wr_acc      = cfg_valid & cfg_ready;
   assign clr         = wr_acc & ((state_reg == S_READY) || (state_reg == S_ERR));
   assign sweep_start = wr_acc & cfg_last;
   assign sweep_en    = (state_reg == S_CHECK);

   fsm_cfg_table #(
      .N_STATES (N_STATES),
      .W        (W)
   ) u_table (
      .clock       (clock),
      .reset       (reset),
      .wr_en       (wr_acc),
      .clr         (clr),
      .wr_idx      (cfg_idx),
      .wr_code     (cfg_code),
      .sweep_start (sweep_start),
      .sweep_en    (sweep_en),
      .codes       (fsm_codes),
      .all_loaded  (all_loaded),
      .bad_idx     (bad_idx),
      .sweep_done  (sweep_done),
      .dup_found   (dup_found)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (wr_acc && cfg_last) state_next = S_CHECK;
         S_CHECK: if (sweep_done)
                     state_next = (bad_idx || !all_loaded || dup_found) ? S_ERR : S_READY;
         S_READY: if (wr_acc)     state_next = cfg_last ? S_CHECK : S_IDLE;
                  else if (start) state_next = S_INIT;
         S_INIT:  state_next = (budget_reg == '0) ? S_DRAIN : S_RUN;
         S_RUN:   if (step_cnt_reg == budget_reg - STEP_W'(1)) state_next = S_DRAIN;
         S_DRAIN: state_next = S_DONE;
         S_DONE:  state_next = S_READY;
         S_ERR:   if (wr_acc) state_next = cfg_last ? S_CHECK : S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they line up with the state they describe.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg    <= S_IDLE;
         cfg_ready    <= 1'b1;
         fsm_reset    <= 1'b1;
         fsm_en       <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         en_d_reg     <= 1'b0;
         budget_reg   <= '0;
         step_cnt_reg <= '0;
         laps_reg     <= '0;
      end else begin
         state_reg <= state_next;
         cfg_ready <= (state_next == S_IDLE) || (state_next == S_READY) || (state_next == S_ERR);
         fsm_reset <= !((state_next == S_RUN) || (state_next == S_DRAIN) || (state_next == S_DONE));
         fsm_en    <= (state_next == S_RUN);
         busy      <= (state_next == S_CHECK) || (state_next == S_INIT) ||
                      (state_next == S_RUN)   || (state_next == S_DRAIN);
         done      <= (state_next == S_DONE);
         err       <= (state_next == S_ERR);
         en_d_reg  <= fsm_en;

         if ((state_reg == S_READY) && (state_next == S_INIT)) begin
            budget_reg <= steps;
         end

         if (state_reg == S_INIT) begin
            step_cnt_reg <= '0;
         end else if (state_reg == S_RUN) begin
            step_cnt_reg <= step_cnt_reg + STEP_W'(1);
         end

         // fsm_y lags fsm_en by one cycle, so laps are judged against the delayed enable.
         if (state_reg == S_INIT) begin
            laps_reg <= '0;
         end else if (en_d_reg && (fsm_y == fsm_codes[W-1:0]) && (laps_reg != '1)) begin
            laps_reg <= laps_reg + STEP_W'(1);
         end
      end
   end

   assign laps = laps_reg;

endmodule

// File: tb/tb_fsm_cfg_sched.sv
// Directed bench for fsm_cfg_sched with a behavioural 9-state FSM that walks
// c0 -> c1 -> ... -> c8 -> c0 on each enabled cycle.
module tb_fsm_cfg_sched;

   localparam int N  = 9;
   localparam int W  = 4;
   localparam int SW = 8;

   logic            clock;
   logic            reset;
   logic            cfg_valid;
   logic            cfg_ready;
   logic [3:0]      cfg_idx;
   logic [W-1:0]    cfg_code;
   logic            cfg_last;
   logic            start;
   logic [SW-1:0]   steps;
   logic [W-1:0]    fsm_y;
   logic [N*W-1:0]  fsm_codes;
   logic            fsm_reset;
   logic            fsm_en;
   logic            busy;
   logic            done;
   logic            err;
   logic [SW-1:0]   laps;

   int n_cmp = 0;
   int n_bad = 0;
   logic [63:0] sb[$];

   int c_seq[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
   int c_dup[9] = '{1, 2, 3, 4, 5, 3, 7, 8, 9};

   fsm_cfg_sched dut (
      .clock     (clock),
      .reset     (reset),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_idx   (cfg_idx),
      .cfg_code  (cfg_code),
      .cfg_last  (cfg_last),
      .start     (start),
      .steps     (steps),
      .fsm_y     (fsm_y),
      .fsm_codes (fsm_codes),
      .fsm_reset (fsm_reset),
      .fsm_en    (fsm_en),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .laps      (laps)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Programmable FSM with all inputs tied high: advances one code per enabled cycle.
   int s_idx = 0;
   int s_nxt;
   always_comb s_nxt = (s_idx == N - 1) ? 0 : s_idx + 1;
   always @(posedge clock) begin
      if (fsm_reset) begin
         s_idx <= 0;
         fsm_y <= fsm_codes[W-1:0];
      end else if (fsm_en) begin
         s_idx <= s_nxt;
         fsm_y <= fsm_codes[s_nxt*W +: W];
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic sb_check(input string tag, input logic [63:0] obs);
      logic [63:0] e;
      if (sb.size() == 0) begin
         n_cmp++;
         n_bad++;
         $error("FAIL %s: observed %0d expected none (scoreboard empty)", tag, obs);
      end else begin
         e = sb.pop_front();
         check(tag, obs, e);
      end
   endtask

   task automatic write(input int idx, input int code, input bit last);
      cfg_valid = 1'b1;
      cfg_idx   = idx[3:0];
      cfg_code  = code[W-1:0];
      cfg_last  = last;
      tick();
      cfg_valid = 1'b0;
      cfg_last  = 1'b0;
   endtask

   // Writes idx 0..7, then the final code at last_idx with cfg_last, and checks the sweep.
   task automatic load(input int c[9], input int last_idx, input bit exp_err);
      logic [N*W-1:0] exp_codes;
      int n;
      for (int k = 0; k < N; k++) exp_codes[k*W +: W] = c[k][W-1:0];
      sb.push_back(64'd36);
      sb.push_back({63'd0, exp_err});
      for (int k = 0; k < N - 1; k++) write(k, c[k], 1'b0);
      write(last_idx, c[N-1], 1'b1);
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         tick();
      end
      sb_check("check_cycles", 64'(n));
      sb_check("check_err", {63'd0, err});
      check("ready_after_check", {63'd0, cfg_ready}, 64'd1);
      if (last_idx == N - 1) check("table_codes", 64'(fsm_codes), 64'(exp_codes));
      $display("load last_idx=%0d: check %0d cycles, err=%0b", last_idx, n, err);
   endtask

   task automatic run(input int s);
      int cyc;
      int en_cnt;
      sb.push_back(64'(s));
      sb.push_back(64'(s + 2));
      sb.push_back(64'(s / 9));
      start = 1'b1;
      steps = s[SW-1:0];
      tick();
      start = 1'b0;
      check("init_reset", {63'd0, fsm_reset}, 64'd1);
      cyc = 0;
      en_cnt = 0;
      while (done !== 1'b1 && cyc < 400) begin
         if (fsm_en === 1'b1) en_cnt++;
         tick();
         cyc++;
      end
      sb_check("run_en_cycles", 64'(en_cnt));
      sb_check("run_done_cycle", 64'(cyc));
      sb_check("run_laps", 64'(laps));
      tick();
      check("done_one_cycle", {63'd0, done}, 64'd0);
      check("ready_after_run", {63'd0, cfg_ready}, 64'd1);
      check("laps_held", 64'(laps), 64'(s / 9));
      $display("run steps=%0d: en=%0d done@%0d laps=%0d", s, en_cnt, cyc, laps);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int en_cnt;
      int cyc;
      reset = 1'b1;
      cfg_valid = 1'b0;
      cfg_idx = '0;
      cfg_code = '0;
      cfg_last = 1'b0;
      start = 1'b0;
      steps = '0;
      repeat (3) tick();
      check("rst_cfg_ready", {63'd0, cfg_ready}, 64'd1);
      check("rst_fsm_reset", {63'd0, fsm_reset}, 64'd1);
      check("rst_fsm_en", {63'd0, fsm_en}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_err", {63'd0, err}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_laps", 64'(laps), 64'd0);
      check("rst_codes", 64'(fsm_codes), 64'd0);
      $display("reset: ready=%0b fsm_reset=%0b laps=%0d", cfg_ready, fsm_reset, laps);
      reset = 1'b0;
      tick();

      load(c_seq, 8, 1'b0);
      run(20);
      run(9);
      run(0);

      load(c_dup, 8, 1'b1);
      start = 1'b1;
      steps = 8'd5;
      tick();
      start = 1'b0;
      check("err_start_busy", {63'd0, busy}, 64'd0);
      check("err_held", {63'd0, err}, 64'd1);
      write(0, 0, 1'b0);
      check("err_cleared", {63'd0, err}, 64'd0);
      load(c_seq, 8, 1'b0);

      load(c_seq, 12, 1'b1);
      load(c_seq, 8, 1'b0);

      // Write and start together: the write wins.
      cfg_valid = 1'b1;
      cfg_idx = 4'd0;
      cfg_code = 4'd0;
      start = 1'b1;
      steps = 8'd4;
      tick();
      cfg_valid = 1'b0;
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("wr_start_busy", {63'd0, busy}, 64'd0);
         check("wr_start_en", {63'd0, fsm_en}, 64'd0);
         tick();
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      check("idle_start_ignored", {63'd0, busy}, 64'd0);
      $display("write+start collision: busy=%0b en=%0b", busy, fsm_en);
      load(c_seq, 8, 1'b0);

      // Reset during RUN after the fifth enabled step.
      start = 1'b1;
      steps = 8'd20;
      tick();
      start = 1'b0;
      en_cnt = 0;
      cyc = 0;
      while (en_cnt < 5 && cyc < 50) begin
         if (fsm_en === 1'b1) en_cnt++;
         if (en_cnt < 5) tick();
         cyc++;
      end
      check("midrun_steps", 64'(en_cnt), 64'd5);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrun_en", {63'd0, fsm_en}, 64'd0);
      check("midrun_fsm_reset", {63'd0, fsm_reset}, 64'd1);
      check("midrun_busy", {63'd0, busy}, 64'd0);
      check("midrun_table", 64'(fsm_codes), 64'd0);
      check("midrun_laps", 64'(laps), 64'd0);
      start = 1'b1;
      steps = 8'd5;
      repeat (3) begin
         tick();
         check("post_reset_start", {63'd0, busy | fsm_en}, 64'd0);
      end
      start = 1'b0;
      $display("mid-run reset: en=%0b fsm_reset=%0b busy=%0b", fsm_en, fsm_reset, busy);
      load(c_seq, 8, 1'b0);
      run(9);

      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
